// File: rtl/simple_spi_slave.sv
// SPI mode 0 slave (CPOL=0, CPHA=0), 8-bit frames, MSB first.
// SCLK/CS_n/MOSI are oversampled in the clk domain; all shifting happens on
// detected edges of the synchronized SCLK. A single holding register feeds
// the transmit shifter so a host can stream bytes under one CS assertion.
module simple_spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_spi_clk,
  input  logic       i_spi_cs_n,
  input  logic       i_spi_mosi,
  output logic       o_spi_miso,
  output logic       o_spi_miso_oe,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_tx_underrun,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_busy
);

  // Synchronizer lane order is {mosi, cs_n, sclk}. Idle values (SCLK low,
  // CS_n high) are the reset values so leaving reset never fakes an edge.
  localparam logic [2:0] SYNC_RST = 3'b010;

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic                        sclk_s, cs_n_s, mosi_s;
  logic                        sclk_q, cs_n_q;
  logic                        sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic                        sel, cs_active;
  logic                        load, shift_en, wr;

  logic [7:0] tx_shift;
  logic [6:0] rx_shift;
  logic [2:0] bit_cnt;
  logic       byte_done;  // 8th rise seen; next SCLK fall starts a new byte
  logic [7:0] hold_byte;
  logic       hold_full;

  // Input synchronizer chain for the three SPI pins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {i_spi_mosi, i_spi_cs_n, i_spi_clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sclk_s = sync_q[SYNC_STAGES-1][0];
  assign cs_n_s = sync_q[SYNC_STAGES-1][1];
  assign mosi_s = sync_q[SYNC_STAGES-1][2];

  // Previous synchronized SCLK / CS_n for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b0;
      cs_n_q <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      cs_n_q <= cs_n_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_n_q & ~cs_n_s;
  assign cs_rise   = ~cs_n_q & cs_n_s;

  // sel gates edge actions; cs_active drives the pins and lines up with the
  // register load that happens on the CS falling edge.
  assign sel       = ~cs_n_s;
  assign cs_active = ~cs_n_q;

  assign load     = sel & (cs_fall | (sclk_fall & byte_done));
  assign shift_en = sel & sclk_fall & ~byte_done & (bit_cnt != 3'd0);

  assign o_tx_ready = ~hold_full;
  assign wr         = i_tx_valid & ~hold_full;

  // Holding register: a write only lands when empty, so a write that
  // coincides with a load point fills it for the following byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_byte <= 8'h00;
      hold_full <= 1'b0;
    end else if (wr) begin
      hold_byte <= i_tx_byte;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  // Shift engine: load/shift TX on SCLK falls, sample RX on SCLK rises
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift      <= IDLE_BYTE;
      rx_shift      <= '0;
      bit_cnt       <= 3'd0;
      byte_done     <= 1'b0;
      o_rx_byte     <= 8'h00;
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
      if (cs_rise) begin
        // Abort: partial byte is discarded, holding register untouched
        tx_shift  <= IDLE_BYTE;
        rx_shift  <= '0;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
      end else if (sel) begin
        if (load) begin
          tx_shift      <= hold_full ? hold_byte : IDLE_BYTE;
          bit_cnt       <= 3'd0;
          byte_done     <= 1'b0;
          o_tx_underrun <= ~hold_full;
        end else if (shift_en) begin
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
        if (sclk_rise) begin
          rx_shift <= {rx_shift[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            o_rx_byte  <= {rx_shift, mosi_s};
            o_rx_valid <= 1'b1;
            byte_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign o_spi_miso    = cs_active & tx_shift[7];
  assign o_spi_miso_oe = cs_active;
  assign o_busy        = cs_active;

endmodule

// File: tb/tb_simple_spi_slave.sv
// Bench for simple_spi_slave: a behavioural mode-0 master drives the pins,
// expected RX bytes and expected MISO bytes go into scoreboard queues when
// stimulus is issued and are popped when the DUT/master produce data.
`timescale 1ns/1ps
module tb_simple_spi_slave;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk, spi_cs_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready, tx_underrun;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;

  simple_spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_spi_clk     (spi_clk),
    .i_spi_cs_n    (spi_cs_n),
    .i_spi_mosi    (spi_mosi),
    .o_spi_miso    (spi_miso),
    .o_spi_miso_oe (spi_miso_oe),
    .i_tx_byte     (tx_byte),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_tx_underrun (tx_underrun),
    .o_rx_byte     (rx_byte),
    .o_rx_valid    (rx_valid),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Monitor: log every rx_valid pulse and count underrun pulses
  int         rx_cnt = 0;
  int         ur_cnt = 0;
  logic [7:0] rx_log [64];
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 64] <= rx_byte;
      rx_cnt              <= rx_cnt + 1;
    end
    if (tx_underrun) ur_cnt <= ur_cnt + 1;
  end

  logic [7:0] rx_q   [$];  // expected received bytes
  logic [7:0] miso_q [$];  // expected bytes seen by the master
  int         rd = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Host write into the holding register, bounded wait on o_tx_ready
  task automatic tx_write(input logic [7:0] b);
    int t = 0;
    tx_byte  = b;
    tx_valid = 1'b1;
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_ready_fall", tx_ready, 0);
  endtask

  // One full byte; when last, CS rises with SCLK still high so no trailing
  // fall is seen while selected, then SCLK returns to idle.
  task automatic spi_byte(input logic [7:0] b, input bit last);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      idle(HALF);
      spi_clk = 1'b1;
      r[i]    = spi_miso;
      idle(HALF);
      if (i > 0 || !last) spi_clk = 1'b0;
    end
    if (last) begin
      spi_cs_n = 1'b1;
      idle(2);
      spi_clk = 1'b0;
    end
    chk("miso_byte", r, miso_q.pop_front());
  endtask

  // n rising edges then stop with SCLK high (caller ends the frame)
  task automatic spi_partial(input logic [7:0] b, input int n);
    spi_cs_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      idle(HALF);
      spi_clk = 1'b1;
      idle(HALF);
      if (i < n - 1) spi_clk = 1'b0;
    end
  endtask

  // Compare every expected RX byte against the monitor log, then no extras
  task automatic rx_drain();
    while (rx_q.size() > 0) begin
      chk("rx_present", rx_cnt > rd, 1);
      chk("rx_byte", rx_log[rd % 64], rx_q.pop_front());
      rd++;
    end
    chk("rx_count", rx_cnt, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ur0;
    int t;
    rst = 1'b1; spi_clk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    tx_byte = 8'h00; tx_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    idle(1);
    chk("rst_miso",     spi_miso,    0);
    chk("rst_oe",       spi_miso_oe, 0);
    chk("rst_rx_byte",  rx_byte,     8'h00);
    chk("rst_rx_valid", rx_valid,    0);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_busy",     busy,        0);
    chk("rst_tx_ready", tx_ready,    1);

    // 1: preloaded 0xA5 out, 0x3C in
    tx_write(8'hA5);
    ur0 = ur_cnt;
    rx_q.push_back(8'h3C); miso_q.push_back(8'hA5);
    spi_cs_n = 1'b0;
    idle(6);
    chk("t1_busy", busy, 1);
    chk("t1_oe", spi_miso_oe, 1);
    chk("t1_ready_after_load", tx_ready, 1);
    spi_byte(8'h3C, 1'b1);
    idle(10);
    rx_drain();
    chk("t1_underrun", ur_cnt - ur0, 0);
    chk("t1_busy_end", busy, 0);

    // 2: nothing loaded -> IDLE_BYTE and one underrun at CS fall
    ur0 = ur_cnt;
    rx_q.push_back(8'h81); miso_q.push_back(8'hFF);
    spi_cs_n = 1'b0;
    idle(6);
    chk("t2_underrun_csfall", ur_cnt - ur0, 1);
    spi_byte(8'h81, 1'b1);
    idle(10);
    rx_drain();
    chk("t2_underrun_total", ur_cnt - ur0, 1);
    chk("t2_rx_hold", rx_byte, 8'h81);

    // 3: two bytes under one CS, second byte loaded once ready rises
    tx_write(8'h12);
    ur0 = ur_cnt;
    rx_q.push_back(8'hC3); rx_q.push_back(8'h5A);
    miso_q.push_back(8'h12); miso_q.push_back(8'h34);
    spi_cs_n = 1'b0;
    tx_write(8'h34);
    spi_byte(8'hC3, 1'b0);
    spi_byte(8'h5A, 1'b1);
    idle(10);
    rx_drain();
    chk("t3_underrun", ur_cnt - ur0, 0);

    // 4: abort after 5 rises, then full byte realigns
    t = rx_cnt;
    spi_partial(8'hE7, 5);
    spi_cs_n = 1'b1;
    idle(2);
    spi_clk = 1'b0;
    idle(10);
    chk("t4_no_rx_on_abort", rx_cnt, t);
    rx_q.push_back(8'h96); miso_q.push_back(8'hFF);
    spi_cs_n = 1'b0;
    spi_byte(8'h96, 1'b1);
    idle(10);
    rx_drain();

    // 5: write while full is ignored
    tx_byte = 8'h55; tx_valid = 1'b1;
    @(negedge clk);
    tx_byte = 8'h66;
    idle(5);
    chk("t5_ready_full", tx_ready, 0);
    tx_valid = 1'b0;
    ur0 = ur_cnt;
    rx_q.push_back(8'h0A); miso_q.push_back(8'h55);
    spi_cs_n = 1'b0;
    spi_byte(8'h0A, 1'b1);
    idle(10);
    rx_drain();
    chk("t5_underrun", ur_cnt - ur0, 0);
    chk("t5_ready_empty", tx_ready, 1);

    // 6: reset pulse at SCLK rise 4, then a clean transfer
    tx_write(8'h77);
    spi_partial(8'hAB, 4);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_miso",     spi_miso,    0);
    chk("t6_oe",       spi_miso_oe, 0);
    chk("t6_rx_byte",  rx_byte,     8'h00);
    chk("t6_rx_valid", rx_valid,    0);
    chk("t6_underrun", tx_underrun, 0);
    chk("t6_busy",     busy,        0);
    chk("t6_tx_ready", tx_ready,    1);
    spi_cs_n = 1'b1;
    idle(2);
    spi_clk = 1'b0;
    idle(10);
    tx_write(8'h0F);
    rx_q.push_back(8'hF0); miso_q.push_back(8'h0F);
    spi_cs_n = 1'b0;
    spi_byte(8'hF0, 1'b1);
    idle(10);
    rx_drain();
    chk("t6_rx_hold", rx_byte, 8'hF0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
